drum_step_seq: RTL and testbench

Step sequencer that consumes the tempo toggle produced by the team's clock divider (`clkdiv.hzX`) and turns it into per-track drum trigger pulses. Each transition of the tempo toggle advances a step pointer through a programmable on/off pattern, one bit per track per step. Trigger outputs feed the voice/sample-playback stage downstream. Pattern bits are edited at runtime through a single-bit write port.

---
 rtl/drumbit_pkg.sv | 21 ++
 rtl/toggle_edge.sv | 19 +
 rtl/drum_step_seq.sv | 122 ++++++++++++
 tb/tb_drum_step_seq.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/drumbit_pkg.sv
// Shared types and defaults for the drum step sequencer and the playback stage
// that consumes its triggers.
package drumbit_pkg;

    localparam int DEF_STEPS  = 8;
    localparam int DEF_TRACKS = 4;

    typedef enum logic [1:0] {
        STOPPED,
        ARMED,
        PLAYING
    } seq_state_t;

    typedef logic [DEF_TRACKS-1:0] trig_vec_t;

    // Index width that stays at least one bit for degenerate sizes.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/toggle_edge.sv
// Turns a toggle-style strobe into a one-cycle event: any change of the input
// relative to its registered copy.
module toggle_edge (
    input  logic clk,
    input  logic rst,
    input  logic tick_in,
    output logic ev
);

    logic tick_q_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tick_q_reg <= 1'b0;
        else     tick_q_reg <= tick_in;
    end

    assign ev = tick_in ^ tick_q_reg;

endmodule

// File: rtl/drum_step_seq.sv
// Tempo-driven drum step sequencer: each tempo toggle fires the next step of a
// runtime-editable TRACKS x STEPS on/off pattern as one-cycle trigger pulses.
module drum_step_seq
    import drumbit_pkg::*;
#(
    parameter int STEPS  = DEF_STEPS,
    parameter int TRACKS = DEF_TRACKS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tick_in,
    input  logic                       run,
    input  logic                       edit_we,
    input  logic [idx_w(TRACKS)-1:0]   edit_track,
    input  logic [idx_w(STEPS)-1:0]    edit_step,
    input  logic                       edit_val,
    input  logic                       clear_all,
    output logic [TRACKS-1:0]          trig,
    output logic [idx_w(STEPS)-1:0]    step_idx,
    output logic                       bar_start,
    output logic                       playing
);

    localparam int SW = idx_w(STEPS);
    localparam int TW = idx_w(TRACKS);

    logic              ev;
    logic [STEPS-1:0]  pattern_reg [TRACKS];
    seq_state_t        state_reg, state_next;
    logic [SW-1:0]     step_reg, step_next;
    logic [SW-1:0]     fire_step;
    logic              fire;
    logic [TRACKS-1:0] trig_reg, trig_next;
    logic              bar_reg, bar_next;
    logic              playing_reg;
    logic              step_ok;

    toggle_edge u_tick (
        .clk     (clk),
        .rst     (rst),
        .tick_in (tick_in),
        .ev      (ev)
    );

    assign step_ok = (32'(edit_step) < STEPS);

    // Pattern rows; a clear beats a coincident write. Out-of-range tracks
    // never match any row, so they fall away naturally.
    for (genvar gi = 0; gi < TRACKS; gi++) begin : g_row
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pattern_reg[gi] <= '0;
            end else if (clear_all) begin
                pattern_reg[gi] <= '0;
            end else if (edit_we && step_ok && (edit_track == TW'(gi))) begin
                pattern_reg[gi][edit_step] <= edit_val;
            end
        end

        // Reads the pre-write pattern, so a same-cycle edit lands next loop.
        assign trig_next[gi] = fire & pattern_reg[gi][fire_step];
    end

    always_comb begin
        state_next = state_reg;
        step_next  = step_reg;
        fire       = 1'b0;
        fire_step  = step_reg;
        case (state_reg)
            STOPPED: begin
                if (run) state_next = ARMED;
            end
            ARMED: begin
                if (!run) begin
                    state_next = STOPPED;
                    step_next  = '0;
                end else if (ev) begin
                    state_next = PLAYING;
                    fire       = 1'b1;
                    fire_step  = '0;
                end
            end
            PLAYING: begin
                if (!run) begin
                    state_next = STOPPED;
                    step_next  = '0;
                end else if (ev) begin
                    fire      = 1'b1;
                    fire_step = (step_reg == SW'(STEPS - 1)) ? '0 : step_reg + 1'b1;
                end
            end
            default: begin
                state_next = STOPPED;
                step_next  = '0;
            end
        endcase
        if (fire) step_next = fire_step;
        bar_next = fire && (fire_step == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= STOPPED;
            step_reg    <= '0;
            trig_reg    <= '0;
            bar_reg     <= 1'b0;
            playing_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            step_reg    <= step_next;
            trig_reg    <= trig_next;
            bar_reg     <= bar_next;
            playing_reg <= (state_next == PLAYING);
        end
    end

    assign trig      = trig_reg;
    assign step_idx  = step_reg;
    assign bar_start = bar_reg;
    assign playing   = playing_reg;

endmodule

// File: tb/tb_drum_step_seq.sv
// Directed bench for drum_step_seq: an 8x4 instance for the main scenarios and
// a 6-step, 3-track instance for non-power-of-two wrap and range guarding.
module tb_drum_step_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, tick_in, run, edit_we, edit_val, clear_all;
    logic [1:0] edit_track;
    logic [2:0] edit_step;
    logic [3:0] trig;
    logic [2:0] step_idx;
    logic       bar_start, playing;

    logic       tick6, run6, we6, val6, clear6;
    logic [1:0] trk6;
    logic [2:0] stp6;
    logic [2:0] trig6;
    logic [2:0] step6;
    logic       bar6, play6;

    int n_checks = 0;
    int n_pass   = 0;

    drum_step_seq #(.STEPS(8), .TRACKS(4)) dut (
        .clk(clk), .rst(rst), .tick_in(tick_in), .run(run),
        .edit_we(edit_we), .edit_track(edit_track), .edit_step(edit_step),
        .edit_val(edit_val), .clear_all(clear_all),
        .trig(trig), .step_idx(step_idx), .bar_start(bar_start), .playing(playing)
    );

    drum_step_seq #(.STEPS(6), .TRACKS(3)) dut6 (
        .clk(clk), .rst(rst), .tick_in(tick6), .run(run6),
        .edit_we(we6), .edit_track(trk6), .edit_step(stp6),
        .edit_val(val6), .clear_all(clear6),
        .trig(trig6), .step_idx(step6), .bar_start(bar6), .playing(play6)
    );

    // Main pattern: track0 = steps {0,4}, track1 = steps {2,6}
    function automatic logic [3:0] exp_trig(input int s);
        case (s)
            0, 4:    return 4'b0001;
            2, 6:    return 4'b0010;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic toggle();
        tick_in = ~tick_in;
        cyc();
    endtask

    task automatic write_bit(input int t, input int s, input int v);
        logic [31:0] tv, sv, vv;
        tv = t; sv = s; vv = v;
        edit_we    = 1'b1;
        edit_track = tv[1:0];
        edit_step  = sv[2:0];
        edit_val   = vv[0];
        cyc();
        edit_we    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick_in = 0; run = 0; edit_we = 0; edit_val = 0; clear_all = 0;
        edit_track = 0; edit_step = 0;
        tick6 = 0; run6 = 0; we6 = 0; val6 = 0; clear6 = 0; trk6 = 0; stp6 = 0;
        cyc(); cyc();
        n_checks++; if (trig !== 4'b0) $display("FAIL reset_trig got=%b want=0000", trig); else n_pass++;
        n_checks++; if (step_idx !== 3'd0) $display("FAIL reset_step got=%0d want=0", step_idx); else n_pass++;
        n_checks++; if (bar_start !== 1'b0) $display("FAIL reset_bar got=%b want=0", bar_start); else n_pass++;
        n_checks++; if (playing !== 1'b0) $display("FAIL reset_playing got=%b want=0", playing); else n_pass++;
        n_checks++; if ({trig6, play6} !== 4'b0) $display("FAIL reset_dut6 got=%b want=0000", {trig6, play6}); else n_pass++;
        rst = 1'b0;
        cyc();
        $display("reset: done");
    endtask

    task automatic test_pattern();
        write_bit(0, 0, 1); write_bit(0, 4, 1); write_bit(1, 2, 1); write_bit(1, 6, 1);
        run = 1'b1;
        cyc();
        n_checks++; if (playing !== 1'b0) $display("FAIL armed_playing got=%b want=0", playing); else n_pass++;
        for (int i = 0; i < 9; i++) begin
            int s;
            s = i % 8;
            toggle();
            n_checks++; if (trig !== exp_trig(s)) $display("FAIL pat_trig ev=%0d got=%b want=%b", i, trig, exp_trig(s)); else n_pass++;
            n_checks++; if (step_idx !== 3'(s)) $display("FAIL pat_step ev=%0d got=%0d want=%0d", i, step_idx, s); else n_pass++;
            n_checks++; if (bar_start !== (s == 0)) $display("FAIL pat_bar ev=%0d got=%b want=%b", i, bar_start, (s == 0)); else n_pass++;
            n_checks++; if (playing !== 1'b1) $display("FAIL pat_playing ev=%0d got=%b want=1", i, playing); else n_pass++;
            $display("pattern: ev=%0d step=%0d trig=%b bar=%b", i, step_idx, trig, bar_start);
        end
        cyc();
        n_checks++; if (trig !== 4'b0) $display("FAIL pulse_width got=%b want=0000", trig); else n_pass++;
        n_checks++; if (step_idx !== 3'd0) $display("FAIL step_hold got=%0d want=0", step_idx); else n_pass++;
        n_checks++; if (bar_start !== 1'b0) $display("FAIL bar_width got=%b want=0", bar_start); else n_pass++;
    endtask

    task automatic test_clkdiv();
        int cnt, exp_s;
        logic toggled;
        cnt = 0; exp_s = 0;
        for (int c = 0; c < 24; c++) begin
            toggled = (cnt == 3);
            if (toggled) begin
                tick_in = ~tick_in;
                cnt = 0;
                exp_s = (exp_s + 1) % 8;
            end else begin
                cnt++;
            end
            cyc();
            n_checks++;
            if (trig !== (toggled ? exp_trig(exp_s) : 4'b0))
                $display("FAIL div_trig cyc=%0d got=%b want=%b", c, trig, (toggled ? exp_trig(exp_s) : 4'b0));
            else n_pass++;
            if (toggled) begin
                n_checks++; if (step_idx !== 3'(exp_s)) $display("FAIL div_step cyc=%0d got=%0d want=%0d", c, step_idx, exp_s); else n_pass++;
                $display("clkdiv: cyc=%0d step=%0d trig=%b", c, step_idx, trig);
            end
        end
    endtask

    task automatic test_same_cycle_write();
        for (int i = 0; i < 4; i++) toggle();
        n_checks++; if (step_idx !== 3'd2) $display("FAIL wr_pre_step got=%0d want=2", step_idx); else n_pass++;
        edit_we = 1'b1; edit_track = 2'd1; edit_step = 3'd3; edit_val = 1'b1;
        toggle();
        edit_we = 1'b0;
        n_checks++; if (trig !== 4'b0000) $display("FAIL wr_old_value got=%b want=0000", trig); else n_pass++;
        n_checks++; if (step_idx !== 3'd3) $display("FAIL wr_step got=%0d want=3", step_idx); else n_pass++;
        for (int i = 0; i < 7; i++) toggle();
        toggle();
        n_checks++; if (trig !== 4'b0010) $display("FAIL wr_new_value got=%b want=0010", trig); else n_pass++;
        n_checks++; if (step_idx !== 3'd3) $display("FAIL wr_next_pass_step got=%0d want=3", step_idx); else n_pass++;
        $display("same_cycle_write: step=%0d trig=%b", step_idx, trig);
    endtask

    task automatic test_stop_on_event();
        toggle(); toggle();
        n_checks++; if (step_idx !== 3'd5) $display("FAIL stop_pre_step got=%0d want=5", step_idx); else n_pass++;
        run = 1'b0;
        toggle();
        n_checks++; if (trig !== 4'b0) $display("FAIL stop_trig got=%b want=0000", trig); else n_pass++;
        n_checks++; if (step_idx !== 3'd0) $display("FAIL stop_step got=%0d want=0", step_idx); else n_pass++;
        n_checks++; if (playing !== 1'b0) $display("FAIL stop_playing got=%b want=0", playing); else n_pass++;
        n_checks++; if (bar_start !== 1'b0) $display("FAIL stop_bar got=%b want=0", bar_start); else n_pass++;
        cyc();
        run = 1'b1;
        toggle();
        n_checks++; if (trig !== 4'b0) $display("FAIL rise_ev_trig got=%b want=0000", trig); else n_pass++;
        n_checks++; if (playing !== 1'b0) $display("FAIL rise_ev_playing got=%b want=0", playing); else n_pass++;
        toggle();
        n_checks++; if (trig !== 4'b0001) $display("FAIL rerun_trig got=%b want=0001", trig); else n_pass++;
        n_checks++; if (step_idx !== 3'd0) $display("FAIL rerun_step got=%0d want=0", step_idx); else n_pass++;
        n_checks++; if (bar_start !== 1'b1) $display("FAIL rerun_bar got=%b want=1", bar_start); else n_pass++;
        n_checks++; if (playing !== 1'b1) $display("FAIL rerun_playing got=%b want=1", playing); else n_pass++;
        $display("stop_on_event: rerun step=%0d trig=%b", step_idx, trig);
    endtask

    task automatic test_clear();
        edit_we = 1'b1; edit_track = 2'd2; edit_step = 3'd5; edit_val = 1'b1; clear_all = 1'b1;
        cyc();
        edit_we = 1'b0; clear_all = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            toggle();
            n_checks++; if (trig !== 4'b0) $display("FAIL clear_trig step=%0d got=%b want=0000", i % 8, trig); else n_pass++;
            n_checks++; if (step_idx !== 3'(i % 8)) $display("FAIL clear_step got=%0d want=%0d", step_idx, i % 8); else n_pass++;
        end
        $display("clear: loop done step=%0d", step_idx);
        we6 = 1'b1; val6 = 1'b1;
        trk6 = 2'd0; stp6 = 3'd7; cyc();
        trk6 = 2'd3; stp6 = 3'd0; cyc();
        trk6 = 2'd2; stp6 = 3'd5; cyc();
        we6 = 1'b0;
        run6 = 1'b1;
        cyc();
        for (int i = 0; i < 7; i++) begin
            int s;
            s = i % 6;
            tick6 = ~tick6;
            cyc();
            n_checks++; if (step6 !== 3'(s)) $display("FAIL s6_step ev=%0d got=%0d want=%0d", i, step6, s); else n_pass++;
            n_checks++; if (trig6 !== ((s == 5) ? 3'b100 : 3'b000)) $display("FAIL s6_trig ev=%0d got=%b want=%b", i, trig6, ((s == 5) ? 3'b100 : 3'b000)); else n_pass++;
            n_checks++; if (bar6 !== (s == 0)) $display("FAIL s6_bar ev=%0d got=%b want=%b", i, bar6, (s == 0)); else n_pass++;
            $display("range: ev=%0d step=%0d trig=%b", i, step6, trig6);
        end
    endtask

    task automatic test_async_reset();
        write_bit(3, 1, 1);
        toggle();
        n_checks++; if (trig !== 4'b1000) $display("FAIL ar_pre_trig got=%b want=1000", trig); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (trig !== 4'b0) $display("FAIL ar_trig got=%b want=0000", trig); else n_pass++;
        n_checks++; if (step_idx !== 3'd0) $display("FAIL ar_step got=%0d want=0", step_idx); else n_pass++;
        n_checks++; if (playing !== 1'b0) $display("FAIL ar_playing got=%b want=0", playing); else n_pass++;
        n_checks++; if (bar_start !== 1'b0) $display("FAIL ar_bar got=%b want=0", bar_start); else n_pass++;
        run = 1'b0;
        #2 rst = 1'b0;
        cyc();
        for (int i = 0; i < 2; i++) begin
            toggle();
            n_checks++; if ({trig, step_idx, playing} !== 8'b0) $display("FAIL ar_ignored got=%b want=00000000", {trig, step_idx, playing}); else n_pass++;
        end
        run = 1'b1;
        cyc();
        toggle();
        n_checks++; if (trig !== 4'b0) $display("FAIL ar_cleared0 got=%b want=0000", trig); else n_pass++;
        n_checks++; if (bar_start !== 1'b1) $display("FAIL ar_bar0 got=%b want=1", bar_start); else n_pass++;
        n_checks++; if (playing !== 1'b1) $display("FAIL ar_replay got=%b want=1", playing); else n_pass++;
        toggle();
        n_checks++; if (trig !== 4'b0) $display("FAIL ar_cleared1 got=%b want=0000", trig); else n_pass++;
        n_checks++; if (step_idx !== 3'd1) $display("FAIL ar_step1 got=%0d want=1", step_idx); else n_pass++;
        $display("async_reset: step=%0d trig=%b", step_idx, trig);
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_clkdiv();
        test_same_cycle_write();
        test_stop_on_event();
        test_clear();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_checks);
        $fatal(1, "timeout");
    end

endmodule
